// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - error statistics monitor for approximate 32x32 multipliers
// Three-stage pipeline: capture, exact product and |error|, statistics accumulate.
module approx_mult_err_monitor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32,
    parameter int ACC_W = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [2*WIDTH-1:0]   z_approx,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     err_sum,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     under_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     num_q;
    logic [CNT_W-1:0]     accepted;
    logic                 take;
    logic                 start_run;

    logic                 v1, v2;
    logic [WIDTH-1:0]     x1, y1;
    logic [2*WIDTH-1:0]   z1;
    logic [2*WIDTH-1:0]   exact1;
    logic [2*WIDTH-1:0]   diff2;
    logic                 lt2;
    logic [ACC_W:0]       sum_ext;

    assign in_ready  = (state == RUN) && (accepted < num_q);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign take      = in_valid && in_ready;
    assign start_run = start && ((state == IDLE) || (state == DONE));

    assign exact1  = (2*WIDTH)'(x1) * (2*WIDTH)'(y1);
    assign sum_ext = {1'b0, err_sum} + (ACC_W+1)'(diff2);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accepted == num_q) state_next = DRAIN;
            DRAIN:   if (!v1 && !v2) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            num_q    <= '0;
            accepted <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DRAIN) && !v1 && !v2;
            if (start_run) begin
                num_q    <= num_samples;
                accepted <= '0;
            end else if (take) begin
                accepted <= accepted + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            x1    <= '0;
            y1    <= '0;
            z1    <= '0;
            diff2 <= '0;
            lt2   <= 1'b0;
        end else begin
            v1 <= take;
            v2 <= v1;
            if (take) begin
                x1 <= x;
                y1 <= y;
                z1 <= z_approx;
            end
            if (v1) begin
                diff2 <= (exact1 > z1) ? exact1 - z1 : z1 - exact1;
                lt2   <= (z1 < exact1);
            end
        end
    end

    // Stats only move on a retiring sample; start clears them (pipeline is empty then)
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            err_sum   <= '0;
            err_max   <= '0;
            err_cnt   <= '0;
            under_cnt <= '0;
        end else if (v2) begin
            err_sum   <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            if (diff2 > err_max) err_max <= diff2;
            err_cnt   <= err_cnt + CNT_W'(diff2 != '0);
            under_cnt <= under_cnt + CNT_W'(lt2);
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb/tb_approx_mult_err_monitor.sv - self-checking bench for approx_mult_err_monitor
module tb_approx_mult_err_monitor;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  num_samples;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  x, y;
    logic [63:0]  z_approx;
    logic         busy, done;
    logic [95:0]  err_sum;
    logic [63:0]  err_max;
    logic [31:0]  err_cnt, under_cnt;

    approx_mult_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
        .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
        .err_cnt(err_cnt), .under_cnt(under_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           n;
        logic [31:0]  xs [3];
        logic [31:0]  ys [3];
        logic [63:0]  zs [3];
        logic [95:0]  e_sum;
        logic [63:0]  e_max;
        int           e_cnt;
        int           e_under;
    } vec_t;

    vec_t tbl [4];

    logic [31:0]  vx [];
    logic [31:0]  vy [];
    logic [63:0]  vz [];

    logic [127:0] m_sum, m_max;
    int           m_cnt, m_under;
    localparam logic [127:0] ACC_MAX = {32'b0, {96{1'b1}}};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: |exact - z| in wide plain arithmetic, sum clamped to 2^96-1.
    task automatic model_add(input logic [31:0] a, input logic [31:0] b, input logic [63:0] z);
        logic [127:0] ex, d;
        ex = {96'b0, a} * {96'b0, b};
        d  = (ex > {64'b0, z}) ? ex - {64'b0, z} : {64'b0, z} - ex;
        m_sum = m_sum + d;
        if (m_sum > ACC_MAX) m_sum = ACC_MAX;
        if (d > m_max) m_max = d;
        if (d != 0) m_cnt++;
        if ({64'b0, z} < ex) m_under++;
    endtask

    // gap: 0 = in_valid always high, 1 = every other cycle, 2 = random
    task automatic drive_run(input string tag, input int n, input int gap);
        int i, guard, last_acc;
        m_sum = 0; m_max = 0; m_cnt = 0; m_under = 0;
        @(negedge clk); start = 1'b1; num_samples = n;
        @(negedge clk); start = 1'b0;
        if (n == 0) check({tag, "_ready_zero"}, in_ready, 0);
        i = 0; guard = 0; last_acc = 0;
        while (i < n && guard < 20 * n + 50) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2) == 0;
                default: in_valid = ($urandom % 4) != 0;
            endcase
            x = vx[i]; y = vy[i]; z_approx = vz[i];
            if (in_valid && in_ready) begin
                model_add(vx[i], vy[i], vz[i]);
                last_acc = cyc;
                i++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_accepted"}, i, n);
        check({tag, "_ready_after"}, in_ready, 0);
        guard = 0;
        while (!done && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, done, 1);
        if (n > 0) check({tag, "_done_latency"}, cyc - last_acc, 4);
        check({tag, "_err_sum"}, err_sum, m_sum);
        check({tag, "_err_max"}, err_max, m_max);
        check({tag, "_err_cnt"}, err_cnt, m_cnt);
        check({tag, "_under_cnt"}, under_cnt, m_under);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_hold_sum"}, err_sum, m_sum);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = 0; in_valid = 1'b0;
        x = 0; y = 0; z_approx = 0;

        tbl[0].n = 1;
        tbl[0].xs = '{32'd3, 32'd0, 32'd0}; tbl[0].ys = '{32'd5, 32'd0, 32'd0};
        tbl[0].zs = '{64'd15, 64'd0, 64'd0};
        tbl[0].e_sum = 96'd0; tbl[0].e_max = 64'd0; tbl[0].e_cnt = 0; tbl[0].e_under = 0;
        tbl[1].n = 2;
        tbl[1].xs = '{32'hFFFFFFFF, 32'd2, 32'd0}; tbl[1].ys = '{32'hFFFFFFFF, 32'd2, 32'd0};
        tbl[1].zs = '{64'd0, 64'd6, 64'd0};
        tbl[1].e_sum = 96'hFFFFFFFE00000003; tbl[1].e_max = 64'hFFFFFFFE00000001;
        tbl[1].e_cnt = 2; tbl[1].e_under = 1;
        tbl[2].n = 1;
        tbl[2].xs = '{32'd10, 32'd0, 32'd0}; tbl[2].ys = '{32'd10, 32'd0, 32'd0};
        tbl[2].zs = '{64'd101, 64'd0, 64'd0};
        tbl[2].e_sum = 96'd1; tbl[2].e_max = 64'd1; tbl[2].e_cnt = 1; tbl[2].e_under = 0;
        tbl[3].n = 3;
        tbl[3].xs = '{32'd7, 32'd0, 32'd100}; tbl[3].ys = '{32'd6, 32'hFFFFFFFF, 32'd100};
        tbl[3].zs = '{64'd40, 64'd5, 64'd10000};
        tbl[3].e_sum = 96'd7; tbl[3].e_max = 64'd5; tbl[3].e_cnt = 2; tbl[3].e_under = 1;

        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_sum", err_sum, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            vx = new[3]; vy = new[3]; vz = new[3];
            for (int k = 0; k < 3; k++) begin
                vx[k] = tbl[t].xs[k]; vy[k] = tbl[t].ys[k]; vz[k] = tbl[t].zs[k];
            end
            drive_run($sformatf("vec%0d", t), tbl[t].n, 0);
            check($sformatf("vec%0d_tbl_sum", t), err_sum, {32'b0, tbl[t].e_sum});
            check($sformatf("vec%0d_tbl_max", t), err_max, {64'b0, tbl[t].e_max});
            check($sformatf("vec%0d_tbl_cnt", t), err_cnt, tbl[t].e_cnt);
            check($sformatf("vec%0d_tbl_under", t), under_cnt, tbl[t].e_under);
        end

        drive_run("alt3", 3, 1);
        drive_run("zero", 0, 0);

        // Reset two accepts into a run: in-flight samples must vanish, no done follows
        vx = new[5]; vy = new[5]; vz = new[5];
        for (int k = 0; k < 5; k++) begin
            vx[k] = 32'd1000 + k; vy[k] = 32'd3; vz[k] = 64'd7;
        end
        @(negedge clk); start = 1'b1; num_samples = 5;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; x = vx[k]; y = vy[k]; z_approx = vz[k];
            check($sformatf("abort_ready%0d", k), in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_err_sum", err_sum, 0);
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (done || err_cnt != 0) seen++;
                @(negedge clk);
            end
            check("abort_quiet", seen, 0);
        end

        // Randomized runs against the truncating/perturbing multiplier model
        for (int r = 0; r < 10; r++) begin
            vx = new[1000]; vy = new[1000]; vz = new[1000];
            for (int k = 0; k < 1000; k++) begin
                logic [63:0] ex, dd;
                vx[k] = ($urandom % 16 == 0) ? 32'hFFFFFFFF : $urandom;
                vy[k] = ($urandom % 16 == 0) ? 32'hFFFFFFFF : $urandom;
                ex = {32'b0, vx[k]} * {32'b0, vy[k]};
                dd = 64'($urandom_range(0, 1 << 20));
                case ($urandom % 4)
                    0:       vz[k] = ex;
                    1:       vz[k] = (ex >= dd) ? ex - dd : ex;
                    2:       vz[k] = (ex <= ~dd) ? ex + dd : ex;
                    default: vz[k] = {ex[63:16], 16'b0};
                endcase
            end
            drive_run($sformatf("rand%0d", r), 1000, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
